// File: rtl/proc_pkg.sv
// Shared definitions for the execute unit: instruction fields,
// opcodes, flag positions and controller states.
package proc_pkg;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 27;
  localparam int RD_HI   = 26;
  localparam int RD_LO   = 22;
  localparam int RS1_HI  = 21;
  localparam int RS1_LO  = 17;
  localparam int IMM_BIT = 16;
  localparam int RS2_HI  = 15;
  localparam int RS2_LO  = 11;
  localparam int ISRC_HI = 15;
  localparam int ISRC_LO = 0;

  localparam int F_SIGN  = 3;
  localparam int F_ZERO  = 2;
  localparam int F_OV    = 1;
  localparam int F_CARRY = 0;

  typedef enum logic [4:0] {
    OP_MOVSGPR = 5'd0,
    OP_MOV     = 5'd1,
    OP_ADD     = 5'd2,
    OP_SUB     = 5'd3,
    OP_MUL     = 5'd4,
    OP_OR      = 5'd5,
    OP_AND     = 5'd6,
    OP_XOR     = 5'd7,
    OP_NOT     = 5'd8
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    WB   = 2'd3
  } state_e;

endpackage

// File: rtl/proc_seq_mul.sv
// Iterative shift-add unsigned multiplier, one partial
// product per cycle; done flags the final iteration.
module proc_seq_mul #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  assign done = busy && (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0])
        prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/proc_exec_unit.sv
// Multi-cycle execute core: IR, GPR file, operand latches,
// IDLE/EXEC/MUL/WB controller, ALU and status flags.
module proc_exec_unit
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic              done,
  output logic [3:0]        flags,
  output logic              illegal,
  output logic [DATA_W-1:0] sgpr,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  // Bit i set when register i exists; others read 0, ignore writes.
  localparam logic [31:0] REG_MASK = (NREG >= 32) ? 32'hFFFF_FFFF
                                   : ((32'd1 << NREG) - 32'd1);

  state_e              state;
  logic [31:0]         ir;
  logic [DATA_W-1:0]   gpr [32];
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;

  logic [4:0]          op;
  logic [4:0]          rd;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic                imm;
  logic [15:0]         isrc;
  logic [DATA_W-1:0]   a_rd;
  logic [DATA_W-1:0]   b_rd;

  logic                mul_start;
  logic                mul_busy;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_prod;

  logic [DATA_W-1:0]   res;
  logic [DATA_W:0]     sum;
  logic                wr_gpr;
  logic                wr_sg;
  logic [DATA_W-1:0]   sg_new;
  logic                c;
  logic                ov;
  logic                ill;
  logic [3:0]          f_new;

  assign op   = ir[OP_HI:OP_LO];
  assign rd   = ir[RD_HI:RD_LO];
  assign rs1  = ir[RS1_HI:RS1_LO];
  assign rs2  = ir[RS2_HI:RS2_LO];
  assign imm  = ir[IMM_BIT];
  assign isrc = ir[ISRC_HI:ISRC_LO];

  assign a_rd = REG_MASK[rs1] ? gpr[rs1] : '0;
  assign b_rd = imm ? DATA_W'(isrc)
              : (REG_MASK[rs2] ? gpr[rs2] : '0);

  assign dbg_data = REG_MASK[dbg_addr] ? gpr[dbg_addr] : '0;

  assign instr_ready = (state == IDLE) && !mul_busy;
  assign mul_start   = (state == EXEC) && (op == OP_MUL);

  proc_seq_mul #(
    .W(DATA_W)
  ) u_mul (
    .clk   (clk),
    .rst   (sys_rst),
    .start (mul_start),
    .a     (a_rd),
    .b     (b_rd),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    res    = '0;
    sum    = '0;
    wr_gpr = 1'b1;
    wr_sg  = 1'b0;
    sg_new = sgpr;
    c      = 1'b0;
    ov     = 1'b0;
    ill    = 1'b0;
    case (op)
      OP_MOVSGPR: begin
        res = sgpr;
        c   = flags[F_CARRY];
        ov  = flags[F_OV];
      end
      OP_MOV: res = b_q;
      OP_ADD: begin
        sum = {1'b0, a_q} + {1'b0, b_q};
        res = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        ov  = (a_q[DATA_W-1] == b_q[DATA_W-1])
           && (res[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_SUB: begin
        sum = {1'b0, a_q} - {1'b0, b_q};
        res = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        ov  = (a_q[DATA_W-1] != b_q[DATA_W-1])
           && (res[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_MUL: begin
        res    = mul_prod[DATA_W-1:0];
        wr_sg  = 1'b1;
        sg_new = mul_prod[2*DATA_W-1:DATA_W];
        ov     = |mul_prod[2*DATA_W-1:DATA_W];
      end
      OP_OR:  res = a_q | b_q;
      OP_AND: res = a_q & b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_NOT: res = ~a_q;
      default: begin
        wr_gpr = 1'b0;
        ill    = 1'b1;
      end
    endcase
    f_new = ill ? flags : {res[DATA_W-1], res == '0, ov, c};
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgpr    <= '0;
      flags   <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < 32; i++)
        gpr[i] <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            ir    <= instr;
            state <= EXEC;
          end
        end
        EXEC: begin
          // Sources are frozen here so rdst may alias rsrc1/rsrc2.
          a_q   <= a_rd;
          b_q   <= b_rd;
          state <= (op == OP_MUL) ? MUL : WB;
        end
        MUL: begin
          if (mul_done)
            state <= WB;
        end
        WB: begin
          if (wr_gpr && REG_MASK[rd])
            gpr[rd] <= res;
          if (wr_sg)
            sgpr <= sg_new;
          flags   <= f_new;
          done    <= 1'b1;
          illegal <= ill;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_exec_unit.sv
// Directed bench for proc_exec_unit at DATA_W=16, NREG=32.
// Each task drives one scenario and checks hand-computed values.
module tb_proc_exec_unit;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        done;
  logic [3:0]  flags;
  logic        illegal;
  logic [15:0] sgpr;
  logic [4:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  proc_exec_unit #(
    .DATA_W(16),
    .NREG  (32)
  ) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .done       (done),
    .flags      (flags),
    .illegal    (illegal),
    .sgpr       (sgpr),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  function automatic logic [31:0] ri(input logic [4:0] o,
                                     input logic [4:0] d,
                                     input logic [4:0] s1,
                                     input logic [15:0] k);
    return {o, d, s1, 1'b1, k};
  endfunction

  function automatic logic [31:0] rr(input logic [4:0] o,
                                     input logic [4:0] d,
                                     input logic [4:0] s1,
                                     input logic [4:0] s2);
    return {o, d, s1, 1'b0, s2, 11'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, output int w);
    w = 0;
    instr = ins;
    instr_valid = 1'b1;
    while (!instr_ready && w < 60) begin
      step();
      w++;
    end
    total++;
    if (instr_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept: ready=%b want 1 after %0d cycles",
               instr_ready, w);
    end
    step();
    instr_valid = 1'b0;
    instr = $urandom;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (done !== 1'b1 && c < 100) begin
      step();
      c++;
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic preload();
    int w, c;
    for (int i = 0; i < 32; i++) begin
      send(ri(5'd1, 5'(i), 5'd0, 16'd2), w);
      wait_done(c);
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    sys_rst = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
    total++;
    if (instr_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready: got %b want 1", instr_ready);
    end
    total++;
    if (done !== 1'b0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL rst_pulse: got %b%b want 00", done, illegal);
    end
    total++;
    if (flags !== 4'h0 || sgpr !== 16'h0) begin
      bad++;
      $display("FAIL rst_state: got %h/%h want 0/0", flags, sgpr);
    end
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), v);
      total++;
      if (v !== 16'h0) begin
        bad++;
        $display("FAIL rst_gpr%0d: got %h want 0", i, v);
      end
    end
  endtask

  task automatic test_addi();
    int w;
    logic [15:0] v;
    dbg_addr = 5'd0;
    send(ri(5'd2, 5'd0, 5'd2, 16'd4), w);
    step();
    total++;
    if (done !== 1'b0 || dbg_data !== 16'd2) begin
      bad++;
      $display("FAIL addi_wb: got done=%b r0=%h want 0/0002",
               done, dbg_data);
    end
    step();
    rd(5'd0, v);
    total++;
    if (done !== 1'b1 || v !== 16'd6) begin
      bad++;
      $display("FAIL addi_res: got done=%b r0=%h want 1/0006",
               done, v);
    end
    total++;
    if (flags !== 4'b0000 || instr_ready !== 1'b1) begin
      bad++;
      $display("FAIL addi_flags: got %b rdy=%b want 0000/1",
               flags, instr_ready);
    end
  endtask

  task automatic test_sub();
    int w, c;
    logic [15:0] v;
    send(ri(5'd1, 5'd5, 5'd0, 16'd3), w);
    wait_done(c);
    send(rr(5'd3, 5'd0, 5'd4, 5'd5), w);
    wait_done(c);
    rd(5'd0, v);
    total++;
    if (c !== 2 || v !== 16'hFFFF) begin
      bad++;
      $display("FAIL sub_res: got lat=%0d r0=%h want 2/ffff", c, v);
    end
    total++;
    if (flags !== 4'b1001) begin
      bad++;
      $display("FAIL sub_flags: got %b want 1001", flags);
    end
  endtask

  task automatic test_add_flags();
    int w, c;
    logic [15:0] v;
    send(ri(5'd1, 5'd6, 5'd0, 16'h7FFF), w);
    wait_done(c);
    send(ri(5'd2, 5'd7, 5'd6, 16'h0001), w);
    wait_done(c);
    rd(5'd7, v);
    total++;
    if (v !== 16'h8000 || flags !== 4'b1010) begin
      bad++;
      $display("FAIL add_ov: got %h/%b want 8000/1010", v, flags);
    end
    send(ri(5'd1, 5'd8, 5'd0, 16'hFFFF), w);
    wait_done(c);
    send(ri(5'd2, 5'd9, 5'd8, 16'h0001), w);
    wait_done(c);
    rd(5'd9, v);
    total++;
    if (v !== 16'h0000 || flags !== 4'b0101) begin
      bad++;
      $display("FAIL add_carry: got %h/%b want 0000/0101", v, flags);
    end
  endtask

  task automatic test_mul();
    int w, c;
    logic rdy_hi;
    logic [15:0] v;
    send(ri(5'd1, 5'd10, 5'd0, 16'h1234), w);
    wait_done(c);
    send(ri(5'd1, 5'd11, 5'd0, 16'h0100), w);
    wait_done(c);
    send(rr(5'd4, 5'd1, 5'd10, 5'd11), w);
    c = 0;
    rdy_hi = 1'b0;
    while (done !== 1'b1 && c < 100) begin
      if (instr_ready !== 1'b0)
        rdy_hi = 1'b1;
      step();
      c++;
    end
    total++;
    if (c !== 18) begin
      bad++;
      $display("FAIL mul_lat: got %0d want 18", c);
    end
    total++;
    if (rdy_hi !== 1'b0) begin
      bad++;
      $display("FAIL mul_ready: got high want low while busy");
    end
    rd(5'd1, v);
    total++;
    if (v !== 16'h3400 || sgpr !== 16'h0012) begin
      bad++;
      $display("FAIL mul_res: got %h/%h want 3400/0012", v, sgpr);
    end
    total++;
    if (flags !== 4'b0010) begin
      bad++;
      $display("FAIL mul_flags: got %b want 0010", flags);
    end
    send(rr(5'd0, 5'd2, 5'd0, 5'd0), w);
    wait_done(c);
    rd(5'd2, v);
    total++;
    if (v !== 16'h0012 || flags !== 4'b0010) begin
      bad++;
      $display("FAIL movsgpr: got %h/%b want 0012/0010", v, flags);
    end
  endtask

  task automatic test_illegal();
    int w, c;
    logic [15:0] v;
    send({5'd31, 5'd3, 5'd0, 1'b1, 16'h5555}, w);
    wait_done(c);
    total++;
    if (c !== 2 || illegal !== 1'b1) begin
      bad++;
      $display("FAIL ill_pulse: got lat=%0d ill=%b want 2/1",
               c, illegal);
    end
    rd(5'd3, v);
    total++;
    if (v !== 16'd2 || flags !== 4'b0010 || sgpr !== 16'h0012) begin
      bad++;
      $display("FAIL ill_state: got %h/%b/%h want 0002/0010/0012",
               v, flags, sgpr);
    end
    step();
    total++;
    if (illegal !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL ill_width: got %b%b want 00", illegal, done);
    end
    send(rr(5'd2, 5'd12, 5'd3, 5'd4), w);
    wait_done(c);
    rd(5'd12, v);
    total++;
    if (c !== 2 || v !== 16'd4 || illegal !== 1'b0
        || flags !== 4'b0000) begin
      bad++;
      $display("FAIL ill_next: got lat=%0d r12=%h ill=%b f=%b",
               c, v, illegal, flags);
    end
  endtask

  task automatic test_back_to_back();
    int w, c;
    logic [15:0] v;
    for (int i = 0; i < 3; i++) begin
      send(ri(5'd2, 5'd13, 5'd13, 16'd1), w);
      wait_done(c);
      total++;
      if (w !== 0 || c !== 2) begin
        bad++;
        $display("FAIL b2b_%0d: got wait=%0d lat=%0d want 0/2",
                 i, w, c);
      end
    end
    rd(5'd13, v);
    total++;
    if (v !== 16'd5) begin
      bad++;
      $display("FAIL b2b_res: got %h want 0005", v);
    end
  endtask

  task automatic test_reset_mid_mul();
    int w, c;
    logic seen;
    logic [15:0] v;
    send(rr(5'd4, 5'd1, 5'd10, 5'd11), w);
    repeat (6) step();
    total++;
    if (instr_ready !== 1'b0) begin
      bad++;
      $display("FAIL mrst_busy: got %b want 0", instr_ready);
    end
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    total++;
    if (instr_ready !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL mrst_ctl: got rdy=%b done=%b want 1/0",
               instr_ready, done);
    end
    total++;
    if (sgpr !== 16'h0 || flags !== 4'h0) begin
      bad++;
      $display("FAIL mrst_regs: got %h/%b want 0000/0000",
               sgpr, flags);
    end
    for (int i = 0; i < 14; i++) begin
      rd(5'(i), v);
      total++;
      if (v !== 16'h0) begin
        bad++;
        $display("FAIL mrst_gpr%0d: got %h want 0", i, v);
      end
    end
    seen = 1'b0;
    repeat (25) begin
      if (done !== 1'b0)
        seen = 1'b1;
      step();
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL mrst_nodone: got pulse want none");
    end
    send(ri(5'd2, 5'd1, 5'd0, 16'd9), w);
    wait_done(c);
    rd(5'd1, v);
    total++;
    if (c !== 2 || v !== 16'd9) begin
      bad++;
      $display("FAIL mrst_after: got lat=%0d r1=%h want 2/0009", c, v);
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_addi();
    test_sub();
    test_add_flags();
    test_mul();
    test_illegal();
    test_back_to_back();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
